// File: rtl/player_motion.sv
`default_nettype none
// ============================================================================
//  Module   : player_motion
//  Purpose  : Platformer player kinematics. Horizontal walking with map/screen
//             saturation, jump/rise/fall/land vertical state machine against a
//             platform band (top/bot), and a sticky fell-off-map state.
//             All motion updates happen once per VGA frame tick.
//  Options  : define DOUBLE_JUMP_EN to allow one mid-air jump per landing.
//  Revision : 1.0  initial release
// ============================================================================
module player_motion #(
    parameter int SPEED    = 6,
    parameter int JUMP_V   = 12,
    parameter int GRAVITY  = 1,
    parameter int MAX_FALL = 10,
    parameter int PLAYER_W = 16,
    parameter int PLAYER_H = 16,
    parameter int X_MAX    = 639,
    parameter int Y_MAX    = 479,
    parameter int MAP_LEN  = 4473
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        frame_clk,
    input  logic [7:0]  keycode,
    input  logic        can_move,
    input  logic [13:0] top,
    input  logic [13:0] bot,
    input  logic [9:0]  start_X,
    input  logic [9:0]  start_Y,
    output logic [9:0]  player_X,
    output logic [9:0]  player_Y,
    output logic [13:0] player_location,
    output logic [1:0]  state,
    output logic        fell
);

    typedef enum logic [1:0] {
        ST_GROUNDED = 2'b00,
        ST_RISING   = 2'b01,
        ST_FALLING  = 2'b10,
        ST_FELL     = 2'b11
    } state_t;

    localparam logic [13:0] c_speed    = 14'(SPEED);
    localparam logic [13:0] c_jump_v   = 14'(JUMP_V);
    localparam logic [13:0] c_gravity  = 14'(GRAVITY);
    localparam logic [13:0] c_max_fall = 14'(MAX_FALL);
    localparam logic [13:0] c_player_h = 14'(PLAYER_H);
    localparam logic [13:0] c_x_lim    = 14'(X_MAX - PLAYER_W);
    localparam logic [13:0] c_y_max    = 14'(Y_MAX);
    localparam logic [13:0] c_map_len  = 14'(MAP_LEN);
    localparam logic [7:0]  c_key_left  = 8'h04;
    localparam logic [7:0]  c_key_right = 8'h07;
    localparam logic [7:0]  c_key_jmp_a = 8'h1A;
    localparam logic [7:0]  c_key_jmp_b = 8'h2C;

    logic        frame_s1_q, frame_s1_d, frame_s2_q, frame_s2_d, tick_q, tick_d;
    logic [9:0]  pos_x_q, pos_x_d, pos_y_q, pos_y_d;
    logic [13:0] loc_q, loc_d, vel_q, vel_d;
    state_t      state_q, state_d;
    logic        fell_q, fell_d, jump_prev_q, jump_prev_d;
`ifdef DOUBLE_JUMP_EN
    logic        air_jump_q, air_jump_d;
`endif

    // Shared arithmetic, all 14-bit unsigned with explicit saturation
    logic        w_jump_key, w_jump_req;
    logic [13:0] w_x14, w_y14, w_feet, w_loc_left, w_loc_right, w_x_left, w_x_right;
    logic [13:0] w_rise_y, w_vel_rise, w_vel_fall, w_fall_y, w_fall_feet, w_snap_y;

    assign w_jump_key  = (keycode == c_key_jmp_a) || (keycode == c_key_jmp_b);
    assign w_jump_req  = w_jump_key && !jump_prev_q;
    assign w_x14       = {4'b0, pos_x_q};
    assign w_y14       = {4'b0, pos_y_q};
    assign w_feet      = w_y14 + c_player_h;
    assign w_loc_left  = (loc_q < c_speed) ? 14'd0 : loc_q - c_speed;
    assign w_loc_right = (loc_q >= c_map_len - c_speed) ? c_map_len : loc_q + c_speed;
    assign w_x_left    = (w_x14 < c_speed) ? 14'd0 : w_x14 - c_speed;
    assign w_x_right   = (w_x14 >= c_x_lim - c_speed) ? c_x_lim : w_x14 + c_speed;
    assign w_rise_y    = w_y14 - vel_q;
    assign w_vel_rise  = (vel_q < c_gravity) ? 14'd0 : vel_q - c_gravity;
    assign w_vel_fall  = (vel_q + c_gravity > c_max_fall) ? c_max_fall : vel_q + c_gravity;
    assign w_fall_y    = w_y14 + w_vel_fall;
    assign w_fall_feet = w_fall_y + c_player_h;
    assign w_snap_y    = (top < c_player_h) ? 14'd0 : top - c_player_h;

    // Next-state: frame edge detect plus per-tick horizontal and vertical motion
    always_comb begin
        frame_s1_d  = frame_clk;
        frame_s2_d  = frame_s1_q;
        tick_d      = frame_s1_q & ~frame_s2_q;
        pos_x_d     = pos_x_q;
        pos_y_d     = pos_y_q;
        loc_d       = loc_q;
        vel_d       = vel_q;
        state_d     = state_q;
        fell_d      = fell_q;
        jump_prev_d = jump_prev_q;
`ifdef DOUBLE_JUMP_EN
        air_jump_d  = air_jump_q;
`endif
        if (tick_q && (state_q != ST_FELL)) begin
            jump_prev_d = w_jump_key;
            if (keycode == c_key_left) begin
                loc_d = w_loc_left;
                if (can_move) pos_x_d = 10'(w_x_left);
            end else if (keycode == c_key_right) begin
                loc_d = w_loc_right;
                if (can_move) pos_x_d = 10'(w_x_right);
            end

            case (state_q)
                ST_GROUNDED: begin
                    if (w_jump_req) begin
                        vel_d   = c_jump_v;
                        state_d = ST_RISING;
                    end else if (top > w_feet) begin
                        vel_d   = 14'd0;
                        state_d = ST_FALLING;
                    end else if (top < w_feet) begin
                        pos_y_d = 10'(w_snap_y);
                    end
                end
                ST_RISING: begin
`ifdef DOUBLE_JUMP_EN
                    if (w_jump_req && air_jump_q) begin
                        vel_d      = c_jump_v;
                        air_jump_d = 1'b0;
                    end else
`endif
                    if (vel_q > w_y14) begin
                        // Would go above the screen: clamp and start falling
                        pos_y_d = 10'd0;
                        vel_d   = 14'd0;
                        state_d = ST_FALLING;
                    end else if ((w_feet > bot) && (w_rise_y <= bot)) begin
                        // Head hits the underside of the platform band
                        pos_y_d = 10'(bot + 14'd1);
                        vel_d   = 14'd0;
                        state_d = ST_FALLING;
                    end else begin
                        pos_y_d = 10'(w_rise_y);
                        vel_d   = w_vel_rise;
                        if (w_vel_rise == 14'd0) state_d = ST_FALLING;
                    end
                end
                ST_FALLING: begin
`ifdef DOUBLE_JUMP_EN
                    if (w_jump_req && air_jump_q) begin
                        vel_d      = c_jump_v;
                        air_jump_d = 1'b0;
                        state_d    = ST_RISING;
                    end else
`endif
                    if ((w_feet <= top) && (w_feet + w_vel_fall >= top)) begin
                        pos_y_d = 10'(w_snap_y);
                        vel_d   = 14'd0;
                        state_d = ST_GROUNDED;
`ifdef DOUBLE_JUMP_EN
                        air_jump_d = 1'b1;
`endif
                    end else begin
                        pos_y_d = 10'(w_fall_y);
                        vel_d   = w_vel_fall;
                        if (w_fall_feet > c_y_max) begin
                            state_d = ST_FELL;
                            fell_d  = 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // State registers; reset wins over a same-cycle tick
    always_ff @(posedge Clk) begin
        if (Reset) begin
            frame_s1_q  <= 1'b0;
            frame_s2_q  <= 1'b0;
            tick_q      <= 1'b0;
            pos_x_q     <= start_X;
            pos_y_q     <= start_Y;
            loc_q       <= {4'b0, start_X};
            vel_q       <= 14'd0;
            state_q     <= ST_GROUNDED;
            fell_q      <= 1'b0;
            jump_prev_q <= 1'b0;
`ifdef DOUBLE_JUMP_EN
            air_jump_q  <= 1'b1;
`endif
        end else begin
            frame_s1_q  <= frame_s1_d;
            frame_s2_q  <= frame_s2_d;
            tick_q      <= tick_d;
            pos_x_q     <= pos_x_d;
            pos_y_q     <= pos_y_d;
            loc_q       <= loc_d;
            vel_q       <= vel_d;
            state_q     <= state_d;
            fell_q      <= fell_d;
            jump_prev_q <= jump_prev_d;
`ifdef DOUBLE_JUMP_EN
            air_jump_q  <= air_jump_d;
`endif
        end
    end

    assign player_X        = pos_x_q;
    assign player_Y        = pos_y_q;
    assign player_location = loc_q;
    assign state           = state_q;
    assign fell            = fell_q;

endmodule
`default_nettype wire

// File: doc/player_motion.md
PLAYER_MOTION -- requirements
Module: player_motion

Interface
REQ-001 Parameter SPEED, 6, horizontal pixels per frame tick.
REQ-002 Parameter JUMP_V, 12, initial upward velocity in pixels per tick.
REQ-003 Parameter GRAVITY, 1, velocity change per tick.
REQ-004 Parameter MAX_FALL, 10, downward velocity cap.
REQ-005 Parameter PLAYER_W, 16, sprite width; PLAYER_H, 16, sprite height.
REQ-006 Parameters X_MAX, 639; Y_MAX, 479; MAP_LEN, 4473 (7*X_MAX), last map column.
REQ-007 Clk  input  1  system clock; the only clock.
REQ-008 Reset  input  1  synchronous, active-high reset.
REQ-009 frame_clk  input  1  VGA frame clock, sampled on Clk.
REQ-010 keycode  input  8  keyboard code: 0x04 left, 0x07 right, 0x1A or 0x2C jump.
REQ-011 can_move  input  1  1 = player moves on screen; 0 = screen scrolls and player_X holds.
REQ-012 top, bot  input  14 each  platform band Y limits under player_location.
REQ-013 start_X, start_Y  input  10 each  spawn position.
REQ-014 player_X, player_Y  output  10 each  sprite top-left corner on screen.
REQ-015 player_location  output  14  player X position on the map.
REQ-016 state  output  2  00 GROUNDED, 01 RISING, 10 FALLING, 11 FELL.
REQ-017 fell  output  1  sticky "fell off the map" flag.

Function
REQ-018 Tick detection SHALL use a two-stage registered edge detect, giving a 1-cycle tick 2 Clk cycles after frame_clk rises; all updates occur only on tick cycles.
REQ-019 Left and right keys SHALL change player_location by SPEED, saturating at 0 and MAP_LEN.
REQ-020 When can_move=1, player_X SHALL move by SPEED, saturating at 0 and X_MAX-PLAYER_W; when can_move=0, player_X SHALL hold.
REQ-021 The jump request SHALL be a jump key present on this tick and absent on the previous tick; a held key SHALL NOT re-trigger.
REQ-022 The feet value SHALL be player_Y+PLAYER_H; all vertical arithmetic SHALL be 14-bit unsigned with explicit saturation.
REQ-023 GROUNDED: a jump request SHALL set vel=JUMP_V and go to RISING.
REQ-024 GROUNDED with top>feet: the block SHALL go to FALLING with vel=0.
REQ-025 GROUNDED with top<feet: the block SHALL snap player_Y=top-PLAYER_H and stay GROUNDED.
REQ-026 RISING: player_Y-=vel, then vel-=GRAVITY; at vel=0 the block SHALL go to FALLING.
REQ-027 RISING, Y-vel<0: the block SHALL set Y=0, vel=0 and go to FALLING.
REQ-028 RISING, head bump (feet>bot and Y-vel<=bot): the block SHALL set Y=bot+1, vel=0 and go to FALLING.
REQ-029 FALLING: vel=min(vel+GRAVITY, MAX_FALL) first; if feet<=top and feet+vel>=top, the block SHALL set Y=top-PLAYER_H, vel=0 and go to GROUNDED; otherwise Y+=vel.
REQ-030 FALLING with feet>Y_MAX after the update: the block SHALL go to FELL and set fell=1.
REQ-031 FELL SHALL freeze all outputs and ignore keys until Reset.
REQ-032 Horizontal and vertical updates in the same tick SHALL both apply.

Reset
REQ-033 Reset SHALL set player_X=start_X, player_Y=start_Y, player_location=start_X zero-extended, vel=0, state=GROUNDED, fell=0, and clear edge and key history; it takes priority over a same-cycle tick.
REQ-034 Reset asserted mid-jump or in FELL SHALL restore the REQ-033 values on the next Clk edge.

Configuration
REQ-035 With DOUBLE_JUMP_EN defined, one jump request in RISING or FALLING SHALL reload vel=JUMP_V and go to RISING; landing re-arms it.
REQ-036 Without DOUBLE_JUMP_EN, airborne jump requests SHALL be ignored and no air-jump storage SHALL be synthesized.

Verification
REQ-037 Reset, start 100/300, top=300, one tick -> Y=284, GROUNDED.
REQ-038 Right held 10 ticks, can_move=1 -> X=160, location=160; same with can_move=0 -> X=100, location=160.
REQ-039 Location 4470, right for 2 ticks -> 4473, then holds.
REQ-040 Grounded Y=284, jump edge -> RISING for 12 ticks, Y=206, then FALLING; held key gives no re-jump.
REQ-041 Grounded Y=284, top changes to 400 -> FALLING; vel caps at 10; lands on the 15th tick with Y=384, GROUNDED.
REQ-042 top=600 while grounded -> falls; FELL once feet>479, fell=1, keys ignored; Reset -> X=100, Y=300, fell=0.
